alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, 8, operand/result width; must match the shared ALU instance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqX_valid  input  1  (X = 0,1) requester X presents an operation.
REQ-005 reqX_ready  output  1  requester X operation accepted this cycle.
REQ-006 reqX_a, reqX_b  input  N  signed operands for requester X.
REQ-007 reqX_op  input  4  ALU opcode: 0000 add, 0001 sub, 0010 mul, 0011 or, 0100 mod, 0101 and, 0110 copy b, 0111 shl, 1000 div.
REQ-008 rspX_valid  output  1  result for requester X available.
REQ-009 rspX_ready  input  1  requester X consumes its response.
REQ-010 rsp_result  output  N  result of the current response, shared by both ports.
REQ-011 rsp_flags  output  4  {negative, zero, overflow, carry} from the ALU.
REQ-012 rsp_err  output  1  operation rejected: illegal opcode or divide/modulus by zero.
REQ-013 alu_a, alu_b  output  N  operands to the shared ALU.
REQ-014 alu_ctrl  output  4  opcode to the shared ALU.
REQ-015 alu_result  input  N  combinational ALU result.
REQ-016 alu_flags  input  4  combinational ALU flags.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 op_count  output  16  count of completed responses; saturates at 16'hFFFF.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-020 In IDLE, reqX_ready SHALL be asserted combinationally only for the granted requester with reqX_valid high; at most one ready at a time.
REQ-021 Arbitration SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted.
REQ-022 last_grant SHALL update only on acceptance.
REQ-023 On acceptance, the block SHALL register a, b, op and the grant ID, and move IDLE->EXEC.
REQ-024 alu_a, alu_b and alu_ctrl SHALL be driven from the operand registers at all times.
REQ-025 In EXEC (one cycle), the block SHALL capture alu_result and alu_flags into the response registers and move EXEC->RESP.
REQ-026 Legal opcodes are 0000-1000; for an illegal opcode, the captured result SHALL be 0, flags 4'b0000, and err 1.
REQ-027 For op 0100 or 1000 with b == 0, the captured result SHALL be 0, flags 4'b0000, and err 1; the ALU output is ignored.
REQ-028 In RESP, rspX_valid SHALL be high only for the granted ID.
REQ-029 rsp_result, rsp_flags and rsp_err SHALL be held stable while rspX_valid is high and rspX_ready is low.
REQ-030 The response SHALL complete in the cycle rspX_valid && rspX_ready; the FSM then moves RESP->IDLE and op_count increments.
REQ-031 Latency: acceptance at edge T; rspX_valid high from T+2.
REQ-032 Throughput: at most one operation per 3 cycles.
REQ-033 No new request SHALL be accepted outside IDLE; reqX_ready SHALL be low in EXEC and RESP.
REQ-034 rspY_ready for the non-granted requester SHALL be ignored.
REQ-035 Request inputs changing while not accepted SHALL have no effect.
REQ-036 busy SHALL equal (state != IDLE).

Reset
REQ-037 While rst is high, the block SHALL hold: state IDLE, last_grant = 1 (requester 0 wins first tie), all ready/valid outputs 0, alu_a/alu_b 0, alu_ctrl 4'b0000, rsp_result 0, rsp_flags 0, rsp_err 0, op_count 0.
REQ-038 Reset asserted in EXEC or RESP SHALL abort the transaction: no response issued, op_count not incremented.
REQ-039 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-040 req0 add a=5 b=3, req1 idle -> req0_ready at T; rsp0_valid at T+2; result 8, flags 0000, err 0; op_count 1.
REQ-041 Both valid after reset: req0 sub 3-5, req1 mul 4*4 -> req0 first: result 8'hFE, flags 1000. Then req1: result 16, flags 0000. The next simultaneous pair grants req0 again.
REQ-042 req1 div a=7 b=0 -> rsp1_valid with result 0, flags 0000, err 1; op mod a=7 b=0 gives the same response.
REQ-043 req0 op 4'b1111 -> err 1, result 0.
REQ-044 rsp0_ready low for 5 cycles -> rsp0_valid and data stable, both reqX_ready low, busy 1; ready high -> IDLE next cycle.
REQ-045 rst pulsed during EXEC -> no rspX_valid ever; outputs at reset values; op_count 0; the next request is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: accept (IDLE), capture ALU output (EXEC), hand back (RESP).
module alu_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         busy,
  output logic [15:0]  op_count
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_MOD     = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIV     = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MAX_LEG = OP_W'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [OP_W-1:0] op_q;
  logic            grant_id;
  logic            last_grant;

  logic            grant_c;
  logic            accept_c;
  logic            reject_c;
  logic            rsp_done_c;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign accept_c   = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept_c && !grant_c;
  assign req1_ready = accept_c &&  grant_c;

  // Illegal opcodes and zero divisors bypass the ALU output entirely.
  assign reject_c = (op_q > OP_MAX_LEG) ||
                    (((op_q == OP_MOD) || (op_q == OP_DIV)) && (b_q == '0));

  assign rsp_done_c = grant_id ? rsp1_ready : rsp0_ready;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_q        <= grant_c ? req1_a  : req0_a;
            b_q        <= grant_c ? req1_b  : req0_b;
            op_q       <= grant_c ? req1_op : req0_op;
            grant_id   <= grant_c;
            last_grant <= grant_c;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (reject_c) begin
            rsp_result <= '0;
            rsp_flags  <= FLAG_W'(0);
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
          end
          rsp0_valid <= ~grant_id;
          rsp1_valid <=  grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done_c) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + CNT_W'(1);
            end
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, round-robin and reset sequences, then random traffic
// against a rule-level reference model. A behavioural ALU stands in for the shared instance.
module tb_alu_arbiter;

  localparam int unsigned N = 8;

  logic         clk, rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl, alu_flags;
  logic         busy;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int last_grant = 1;
  logic [3:0]   op_s [2];
  logic [N-1:0] a_s  [2];
  logic [N-1:0] b_s  [2];

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: returns {negative, zero, overflow, carry, result}; junk on illegal opcodes.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [8:0] s;
    logic v, c;
    r = 8'h00; v = 1'b0; c = 1'b0; s = 9'h0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = 8'($signed(a) * $signed(b));
      4'd3: r = a | b;
      4'd4: r = (b == 8'h00 || (a == 8'h80 && b == 8'hFF)) ? 8'h00 : 8'($signed(a) % $signed(b));
      4'd5: r = a & b;
      4'd6: r = b;
      4'd7: r = a << b[2:0];
      4'd8: r = (b == 8'h00) ? 8'h00 : (a == 8'h80 && b == 8'hFF) ? 8'h80 : 8'($signed(a) / $signed(b));
      default: r = 8'hA5;
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

  // Expected response {err, flags, result} from the opcode/divisor rules.
  function automatic logic [12:0] ref_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op > 4'd8 || ((op == 4'd4 || op == 4'd8) && b == 8'h00)) return 13'h0 | 13'h1000;
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    op_s[p] = op; a_s[p] = a; b_s[p] = b;
    if (p == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  // Called at a negedge with requester p's inputs driven; runs accept, EXEC, RESP, completion.
  task automatic go(input int p, input int hold, input logic [7:0] er, input logic [3:0] ef, input logic ee);
    logic [1:0] vexp;
    vexp = (p == 0) ? 2'b10 : 2'b01;
    #1;
    chk("ready_granted", (p == 0) ? req0_ready : req1_ready, 1);
    chk("ready_other", (p == 0) ? req1_ready : req0_ready, 0);
    @(posedge clk);
    last_grant = p;
    @(negedge clk);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    chk("busy_exec", busy, 1);
    chk("ready_exec", {req0_ready, req1_ready}, 0);
    chk("rsp_valid_exec", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    chk("rsp_valid", {rsp0_valid, rsp1_valid}, vexp);
    chk("rsp_result", rsp_result, er);
    chk("rsp_flags", rsp_flags, ef);
    chk("rsp_err", rsp_err, ee);
    chk("ready_resp", {req0_ready, req1_ready}, 0);
    if (p == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {rsp0_valid, rsp1_valid}, vexp);
      chk("hold_data", {rsp_err, rsp_flags, rsp_result}, {ee, ef, er});
      chk("hold_busy", busy, 1);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    if (p == 0) begin rsp0_ready = 1'b1; rsp1_ready = 1'b0; end
    else        begin rsp1_ready = 1'b1; rsp0_ready = 1'b0; end
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    exp_cnt++;
    chk("busy_done", busy, 0);
    chk("rsp_valid_done", {rsp0_valid, rsp1_valid}, 0);
    chk("op_count", op_count, exp_cnt);
  endtask

  task automatic go_ref(input int p, input int hold);
    logic [12:0] r;
    r = ref_fn(op_s[p], a_s[p], b_s[p]);
    go(p, hold, r[7:0], r[11:8], r[12]);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
    chk("rst_rsp_data", {rsp_err, rsp_flags, rsp_result}, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  typedef struct {
    int         port;
    logic [3:0] op;
    logic [7:0] a, b;
    int         hold;
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 4'd0, 8'd5,   8'd3,   0, 8'd8,   4'b0000, 1'b0};
    tbl[1] = '{1, 4'd8, 8'd7,   8'd0,   0, 8'd0,   4'b0000, 1'b1};
    tbl[2] = '{1, 4'd4, 8'd7,   8'd0,   1, 8'd0,   4'b0000, 1'b1};
    tbl[3] = '{0, 4'hF, 8'd3,   8'd4,   0, 8'd0,   4'b0000, 1'b1};
    tbl[4] = '{0, 4'd7, 8'h41,  8'd1,   5, 8'h82,  4'b1000, 1'b0};
    tbl[5] = '{1, 4'd3, 8'h0F,  8'hF0,  2, 8'hFF,  4'b1000, 1'b0};
    tbl[6] = '{1, 4'd5, 8'h0F,  8'hF0,  0, 8'h00,  4'b0100, 1'b0};
    tbl[7] = '{0, 4'd6, 8'h00,  8'h7E,  0, 8'h7E,  4'b0000, 1'b0};

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    #1 chk_reset_outputs();
    req0_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b);
      go(tbl[i].port, tbl[i].hold, tbl[i].res, tbl[i].flg, tbl[i].err);
    end

    // Tie after reset goes to requester 0, then requester 1, then 0 again.
    rst = 1'b1; @(negedge clk); rst = 1'b0; exp_cnt = 0; last_grant = 1;
    drive(0, 4'd1, 8'd3, 8'd5);
    drive(1, 4'd2, 8'd4, 8'd4);
    go(0, 0, 8'hFE, 4'b1000, 1'b0);
    go(1, 0, 8'd16, 4'b0000, 1'b0);
    drive(0, 4'd0, 8'd1, 8'd1);
    drive(1, 4'd0, 8'd2, 8'd2);
    go(0, 0, 8'd2, 4'b0000, 1'b0);
    go(1, 0, 8'd4, 4'b0000, 1'b0);

    // Reset in EXEC aborts the transaction; the next request is served normally.
    drive(1, 4'd0, 8'd9, 8'd9);
    #1 chk("abort_accept", req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0; exp_cnt = 0; last_grant = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
      chk("abort_op_count", op_count, 0);
    end
    drive(1, 4'd0, 8'd9, 8'd9);
    go(1, 0, 8'd18, 4'b0000, 1'b0);

    for (int it = 0; it < 60; it++) begin
      int mode, w;
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        logic [3:0] op;
        logic [7:0] b;
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 8));
        b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        if (mode == 2 || mode == p) drive(p, op, 8'($urandom), b);
      end
      if (mode < 2) begin
        go_ref(mode, int'($urandom_range(0, 2)));
      end else begin
        w = (last_grant == 1) ? 0 : 1;
        go_ref(w, int'($urandom_range(0, 2)));
        go_ref(1 - w, int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
